// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop bit,
// each held BIT_PERIOD clocks. All outputs are driven straight from flops.
module uart_tx_block #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CNT_W = $clog2(BIT_PERIOD);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     period_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 period_roll;

    assign period_roll = (period_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            period_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    serial_out <= 1'b1;
                    if (tx_start && !tx_busy) begin
                        shift_reg  <= tx_data;
                        period_cnt <= '0;
                        bit_idx    <= '0;
                        state      <= S_START;
                        serial_out <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (period_roll) begin
                        period_cnt <= '0;
                        state      <= S_DATA;
                        serial_out <= shift_reg[0];
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (period_roll) begin
                        period_cnt <= '0;
                        shift_reg  <= shift_reg >> 1;
                        // Output register is loaded one bit ahead of the shift.
                        if (bit_idx == IDX_LAST) begin
                            bit_idx    <= '0;
                            state      <= S_STOP;
                            serial_out <= 1'b1;
                        end else begin
                            bit_idx    <= bit_idx + 1'b1;
                            serial_out <= shift_reg[1];
                        end
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (period_roll) begin
                        period_cnt <= '0;
                        state      <= S_IDLE;
                        serial_out <= 1'b1;
                        tx_busy    <= 1'b0;
                        tx_done    <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    serial_out <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
